// File: rtl/lut_perm_sequencer.sv
// lut_perm_sequencer: walks all 720 permutations of 6 LUT inputs in lexicographic order over valid/ready
// Optional embedded transfer checker drives err when LUT_PERM_SEQ_CHECK_EN is defined
module lut_perm_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        prm_ready,
    output logic        prm_valid,
    output logic [35:0] prm,
    output logic [9:0]  idx,
    output logic        last,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [2:0] p [6];
    logic [2:0] sw [6];
    logic [2:0] nxt [6];
    logic [2:0] j, l;
    logic [9:0] cnt;
    logic xfer;
    assign prm_valid = state == RUN;
    assign busy = state == RUN;
    assign done = state == DONE;
    assign idx = cnt;
    assign last = prm_valid && cnt == 10'd719;
    assign xfer = prm_valid & prm_ready;
    always_comb begin
        prm = '0;
        for (int i = 0; i < 6; i++) prm[6*i +: 6] = 6'd1 << p[i];
    end
    // lexicographic successor: pivot j, swap with rightmost larger l, reverse the tail
    always_comb begin
        j = '0;
        l = '0;
        for (int i = 0; i < 5; i++) if (p[i] < p[i+1]) j = 3'(i);
        for (int i = 0; i < 6; i++) if (3'(i) > j && p[i] > p[j]) l = 3'(i);
        sw = p;
        sw[j] = p[l];
        sw[l] = p[j];
        nxt = sw;
        for (int i = 0; i < 6; i++) if (3'(i) > j) nxt[i] = sw[3'(int'(j) + 6 - i)];
    end
    always_comb begin
        state_n = state;
        if (state == IDLE && start) state_n = RUN;
        if (state == RUN && xfer && cnt == 10'd719) state_n = DONE;
        if (state == DONE) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            for (int i = 0; i < 6; i++) p[i] <= 3'(i);
        end else begin
            state <= state_n;
            if (state == DONE) begin
                cnt <= '0;
                for (int i = 0; i < 6; i++) p[i] <= 3'(i);
            end else if (xfer && cnt != 10'd719) begin
                cnt <= cnt + 10'd1;
                p <= nxt;
            end
        end
    end
`ifdef LUT_PERM_SEQ_CHECK_EN
    logic [9:0] prev;
    logic first, bad;
    logic [5:0] col;
    always_comb begin
        bad = first ? (idx != 10'd0) : (idx != prev + 10'd1);
        col = '0;
        for (int i = 0; i < 6; i++) if (!$onehot(prm[6*i +: 6])) bad = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 6; i++) col[i] = prm[6*i+k];
            if (!$onehot(col)) bad = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            err <= 1'b0;
            first <= 1'b1;
            prev <= '0;
        end else if (xfer) begin
            err <= err | bad;
            first <= 1'b0;
            prev <= idx;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule
